hazard_unit: RTL and testbench



---
 rtl/hazard_unit_if.sv | 36 +++
 rtl/hazard_unit.sv | 73 +++++++
 tb/tb_hazard_unit.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/hazard_unit_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard unit (slave).
// It carries the register-field compares, the forwarding/stall/flush controls and the debug event counters.
interface hazard_unit_if #(
   parameter int CNT_W = 16
);
   logic [4:0]       Rs1E;
   logic [4:0]       Rs2E;
   logic [4:0]       Rs1D;
   logic [4:0]       Rs2D;
   logic [4:0]       RdE;
   logic [4:0]       destReg_m;
   logic [4:0]       destReg_w;
   logic             memoryRead_e;
   logic             RegWriteM;
   logic             RegWriteW;
   logic             zero_hazard;
   logic             jump_hazard;
   logic [1:0]       ForwardAE;
   logic [1:0]       ForwardBE;
   logic             stall;
   logic             Flush;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output Rs1E, Rs2E, Rs1D, Rs2D, RdE, destReg_m, destReg_w,
      output memoryRead_e, RegWriteM, RegWriteW, zero_hazard, jump_hazard,
      input  ForwardAE, ForwardBE, stall, Flush, stall_cnt, flush_cnt
   );

   modport slave (
      input  Rs1E, Rs2E, Rs1D, Rs2D, RdE, destReg_m, destReg_w,
      input  memoryRead_e, RegWriteM, RegWriteW, zero_hazard, jump_hazard,
      output ForwardAE, ForwardBE, stall, Flush, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/hazard_unit.sv
// Hazard resolution for the 5-stage pipeline: combinational forwarding, load-use stall and flush,
// plus two saturating event counters for performance debug.
module hazard_unit #(
   parameter int CNT_W = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   hazard_unit_if.slave  hz
);

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   logic             stall;
   logic             flush;
   logic [1:0]       fwd_a;
   logic [1:0]       fwd_b;
   logic [CNT_W-1:0] stall_count;
   logic [CNT_W-1:0] flush_count;

   // Memory beats Writeback because it holds the younger result; x0 is hardwired and never forwards.
   function automatic logic [1:0] fwd_sel(
      input logic [4:0] rs,
      input logic       we_m,
      input logic [4:0] rd_m,
      input logic       we_w,
      input logic [4:0] rd_w
   );
      logic [1:0] sel;
      sel = FWD_RF;
      if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
         sel = FWD_MEM;
      end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
         sel = FWD_WB;
      end
      return sel;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   always_comb begin
      fwd_a = fwd_sel(hz.Rs1E, hz.RegWriteM, hz.destReg_m, hz.RegWriteW, hz.destReg_w);
      fwd_b = fwd_sel(hz.Rs2E, hz.RegWriteM, hz.destReg_m, hz.RegWriteW, hz.destReg_w);
   end

   // Stall and flush are deliberately left unmasked; the pipeline registers resolve priority.
   always_comb begin
      stall = hz.memoryRead_e && (hz.RdE != 5'd0) &&
              ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
      flush = hz.zero_hazard || hz.jump_hazard;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         if (stall) stall_count <= sat_inc(stall_count);
         if (flush) flush_count <= sat_inc(flush_count);
      end
   end

   assign hz.ForwardAE = fwd_a;
   assign hz.ForwardBE = fwd_b;
   assign hz.stall     = stall;
   assign hz.Flush     = flush;
   assign hz.stall_cnt = stall_count;
   assign hz.flush_cnt = flush_count;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed steps then random traffic against a rule-level reference model,
// with a 16-bit-counter instance and a 2-bit-counter instance driven from the same stimulus.
module tb_hazard_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic [4:0] rs1e, rs2e, rs1d, rs2d, rde, rdm, rdw;
   logic       mread, rwm, rww, zh, jh;

   hazard_unit_if #(.CNT_W(16)) hz ();
   hazard_unit_if #(.CNT_W(2))  hz2 ();

   assign hz.Rs1E = rs1e;          assign hz2.Rs1E = rs1e;
   assign hz.Rs2E = rs2e;          assign hz2.Rs2E = rs2e;
   assign hz.Rs1D = rs1d;          assign hz2.Rs1D = rs1d;
   assign hz.Rs2D = rs2d;          assign hz2.Rs2D = rs2d;
   assign hz.RdE = rde;            assign hz2.RdE = rde;
   assign hz.destReg_m = rdm;      assign hz2.destReg_m = rdm;
   assign hz.destReg_w = rdw;      assign hz2.destReg_w = rdw;
   assign hz.memoryRead_e = mread; assign hz2.memoryRead_e = mread;
   assign hz.RegWriteM = rwm;      assign hz2.RegWriteM = rwm;
   assign hz.RegWriteW = rww;      assign hz2.RegWriteW = rww;
   assign hz.zero_hazard = zh;     assign hz2.zero_hazard = zh;
   assign hz.jump_hazard = jh;     assign hz2.jump_hazard = jh;

   hazard_unit #(.CNT_W(16)) dut  (.clk(clk), .rst_n(rst_n), .hz(hz));
   hazard_unit #(.CNT_W(2))  dut2 (.clk(clk), .rst_n(rst_n), .hz(hz2));

   int n_checks = 0;
   int n_fail   = 0;
   int raw_stall = 0;   // unsaturated event counts since the last reset edge
   int raw_flush = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
      if (rwm && rdm != 0 && rdm == rs) return 2'b10;
      if (rww && rdw != 0 && rdw == rs) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic ref_stall();
      return mread && rde != 0 && (rde == rs1d || rde == rs2d);
   endfunction

   function automatic logic [31:0] sat(input int raw, input int width);
      int maxv;
      maxv = (1 << width) - 1;
      return (raw > maxv) ? maxv : raw;
   endfunction

   task automatic check_comb(input string tag);
      #1;
      check({tag, ".fwdA"},  32'(hz.ForwardAE),  32'(ref_fwd(rs1e)));
      check({tag, ".fwdB"},  32'(hz.ForwardBE),  32'(ref_fwd(rs2e)));
      check({tag, ".stall"}, 32'(hz.stall),      32'(ref_stall()));
      check({tag, ".flush"}, 32'(hz.Flush),      32'(zh | jh));
      check({tag, ".fwdA2"}, 32'(hz2.ForwardAE), 32'(ref_fwd(rs1e)));
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      if (!rst_n) begin
         raw_stall = 0;
         raw_flush = 0;
      end else begin
         if (ref_stall()) raw_stall++;
         if (zh | jh)     raw_flush++;
      end
      #1;
      check({tag, ".scnt"},  32'(hz.stall_cnt),  sat(raw_stall, 16));
      check({tag, ".fcnt"},  32'(hz.flush_cnt),  sat(raw_flush, 16));
      check({tag, ".scnt2"}, 32'(hz2.stall_cnt), sat(raw_stall, 2));
      check({tag, ".fcnt2"}, 32'(hz2.flush_cnt), sat(raw_flush, 2));
   endtask

   task automatic idle();
      rs1e = 0; rs2e = 0; rs1d = 0; rs2d = 0; rde = 0; rdm = 0; rdw = 0;
      mread = 0; rwm = 0; rww = 0; zh = 0; jh = 0;
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      check_comb("all_zero");
      // Forwarding from Memory on both operands
      rwm = 1; rdm = 5; rs1e = 5; check_comb("fwd_mem_a");
      rs2e = 5;                    check_comb("fwd_mem_ab");
      idle();
      rwm = 1; rww = 1; rdm = 7; rdw = 7; rs1e = 7; check_comb("mem_priority");
      check(  "mem_priority.val", 32'(hz.ForwardAE), 32'(2'b10));
      rwm = 0;                     check_comb("fwd_wb");
      check(  "fwd_wb.val", 32'(hz.ForwardAE), 32'(2'b01));
      rwm = 1; rdm = 0; rdw = 0; rs1e = 0; check_comb("x0_no_fwd");
      idle();
      // Load-use stall
      mread = 1; rde = 5; rs1d = 5; check_comb("stall_rs1");
      check(  "stall_rs1.val", 32'(hz.stall), 32'd1);
      rs1d = 3; rs2d = 5;           check_comb("stall_rs2");
      mread = 0;                    check_comb("no_load");
      mread = 1; rde = 0; rs1d = 0; check_comb("rd_x0");
      // Flush alongside stall
      rde = 5; rs1d = 5; rs2d = 0;
      zh = 1;                       check_comb("flush_zero");
      check(  "flush_zero.both", 32'({hz.stall, hz.Flush}), 32'(2'b11));
      zh = 0; jh = 1;               check_comb("flush_jump");
      jh = 0;                       check_comb("flush_none");
      idle();
      rs1e = 1; rs2e = 2; rdm = 3; rdw = 4; check_comb("no_write");
      // Counters: reset, 3 stalls, 2 flushes
      idle();
      tick("rst0"); tick("rst1");
      check("rst.scnt", 32'(hz.stall_cnt), 32'd0);
      rst_n = 1;
      mread = 1; rde = 6; rs1d = 6;
      tick("st1"); tick("st2"); tick("st3");
      idle(); zh = 1;
      tick("fl1"); tick("fl2");
      zh = 0;
      check("cnt.scnt", 32'(hz.stall_cnt), 32'd3);
      check("cnt.fcnt", 32'(hz.flush_cnt), 32'd2);
      rst_n = 0; jh = 1; mread = 1; rde = 2; rs2d = 2;
      check_comb("rst_comb_live");
      tick("mid_rst");
      rst_n = 1;
      for (int i = 0; i < 6; i++) tick("sat");
      check("sat.scnt2", 32'(hz2.stall_cnt), 32'd3);
      check("sat.fcnt2", 32'(hz2.flush_cnt), 32'd3);
      // Random traffic over a small register range to provoke frequent matches
      for (int i = 0; i < 400; i++) begin
         rs1e = 5'($urandom_range(0, 3)); rs2e = 5'($urandom_range(0, 3));
         rs1d = 5'($urandom_range(0, 3)); rs2d = 5'($urandom_range(0, 3));
         rde  = 5'($urandom_range(0, 3)); rdm  = 5'($urandom_range(0, 3));
         rdw  = 5'($urandom_range(0, 3));
         mread = 1'($urandom); rwm = 1'($urandom); rww = 1'($urandom);
         zh = 1'($urandom_range(0, 3) == 0); jh = 1'($urandom_range(0, 3) == 0);
         rst_n = ($urandom_range(0, 49) != 0);
         check_comb("rand");
         tick("rand");
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
